// File: rtl/dmux_8way_pkg.sv
// rtl/dmux_8way_pkg.sv - select width and output select encodings for dmux_8way
package dmux_8way_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5,
    SEL_G = 3'd6,
    SEL_H = 3'd7
  } sel_e;

endpackage

// File: rtl/dmux_2way.sv
// rtl/dmux_2way.sv - 1-to-2 combinational demux, the leaf of the dmux tree
module dmux_2way (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);

  assign a = in & ~sel;
  assign b = in & sel;

endmodule

// File: rtl/dmux_8way.sv
// rtl/dmux_8way.sv - 1-to-8 demux built from a dmux_2way tree with registered outputs
import dmux_8way_pkg::*;

module dmux_8way (
  input  logic             clk,
  input  logic             rst,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             h,
  input  logic             in,
  input  logic [SEL_W-1:0] sel
);

  logic       lo, hi;
  logic [3:0] mid;
  logic [7:0] dec;
  logic [7:0] q;

  // Stage 1 on the MSB: lo feeds a..d, hi feeds e..h
  dmux_2way u_s1 (.in(in), .sel(sel[2]), .a(lo), .b(hi));

  dmux_2way u_s2_lo (.in(lo), .sel(sel[1]), .a(mid[0]), .b(mid[1]));
  dmux_2way u_s2_hi (.in(hi), .sel(sel[1]), .a(mid[2]), .b(mid[3]));

  dmux_2way u_s3_0 (.in(mid[0]), .sel(sel[0]), .a(dec[0]), .b(dec[1]));
  dmux_2way u_s3_1 (.in(mid[1]), .sel(sel[0]), .a(dec[2]), .b(dec[3]));
  dmux_2way u_s3_2 (.in(mid[2]), .sel(sel[0]), .a(dec[4]), .b(dec[5]));
  dmux_2way u_s3_3 (.in(mid[3]), .sel(sel[0]), .a(dec[6]), .b(dec[7]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 8'h00;
    end else begin
      q <= dec;
    end
  end

  assign a = q[0];
  assign b = q[1];
  assign c = q[2];
  assign d = q[3];
  assign e = q[4];
  assign f = q[5];
  assign g = q[6];
  assign h = q[7];

endmodule

// File: tb/tb_dmux_8way.sv
// tb/tb_dmux_8way.sv - table-driven and sequence checks for dmux_8way
import dmux_8way_pkg::*;

module tb_dmux_8way;

  logic             clk;
  logic             rst;
  logic             a, b, c, d, e, f, g, h;
  logic             in;
  logic [SEL_W-1:0] sel;
  logic [7:0]       outs;

  typedef struct {
    logic             in;
    logic [SEL_W-1:0] sel;
    logic [7:0]       exp;
  } vec_t;

  vec_t tbl [16];
  int   n_vec;
  int   n_bad;

  dmux_8way dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .in(in), .sel(sel)
  );

  assign outs = {h, g, f, e, d, c, b, a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08b expected %08b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             pin;
    logic [SEL_W-1:0] psel;
    logic [7:0]       exp;

    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{1'b0, SEL_A, 8'h00};
    tbl[1]  = '{1'b0, SEL_B, 8'h00};
    tbl[2]  = '{1'b0, SEL_C, 8'h00};
    tbl[3]  = '{1'b0, SEL_D, 8'h00};
    tbl[4]  = '{1'b0, SEL_E, 8'h00};
    tbl[5]  = '{1'b0, SEL_F, 8'h00};
    tbl[6]  = '{1'b0, SEL_G, 8'h00};
    tbl[7]  = '{1'b0, SEL_H, 8'h00};
    tbl[8]  = '{1'b1, SEL_A, 8'h01};
    tbl[9]  = '{1'b1, SEL_B, 8'h02};
    tbl[10] = '{1'b1, SEL_C, 8'h04};
    tbl[11] = '{1'b1, SEL_D, 8'h08};
    tbl[12] = '{1'b1, SEL_E, 8'h10};
    tbl[13] = '{1'b1, SEL_F, 8'h20};
    tbl[14] = '{1'b1, SEL_G, 8'h40};
    tbl[15] = '{1'b1, SEL_H, 8'h80};

    // Reset with an active decode pending
    rst = 1'b1;
    in  = 1'b1;
    sel = SEL_D;
    #1;
    check("reset_immediate", outs, 8'h00);
    step();
    check("reset_hold_1", outs, 8'h00);
    step();
    check("reset_hold_2", outs, 8'h00);
    rst = 1'b0;
    step();
    check("first_after_reset", outs, 8'h08);

    for (int i = 0; i < 16; i++) begin
      in  = tbl[i].in;
      sel = tbl[i].sel;
      step();
      check($sformatf("sweep_%0d", i), outs, tbl[i].exp);
    end

    // Latency: output must not move until the next rising edge
    in  = 1'b1;
    sel = SEL_A;
    step();
    check("lat_a_set", outs, 8'h01);
    sel = SEL_H;
    #2;
    check("lat_before_edge", outs, 8'h01);
    step();
    check("lat_after_edge", outs, 8'h80);

    // Mid-operation asynchronous reset pulse between edges
    sel = SEL_F;
    step();
    check("mid_f_set", outs, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", outs, 8'h00);
    rst = 1'b0;
    #1;
    check("mid_rst_released", outs, 8'h00);
    step();
    check("mid_restore", outs, 8'h20);

    // Random one-hot check against the previous cycle's inputs
    for (int i = 0; i < 1000; i++) begin
      pin  = 1'($urandom_range(0, 1));
      psel = 3'($urandom_range(0, 7));
      in   = pin;
      sel  = psel;
      step();
      exp = pin ? (8'h01 << psel) : 8'h00;
      check($sformatf("rand_%0d", i), outs, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmux_8way.md
Name: dmux_8way

Overview:
1-to-8 demultiplexer with registered outputs, part of the basics gate library used by the CPU datapath (control-signal fan-out, register/RAM write-enable decode).
- Routes the 1-bit input `in` to the one output selected by the 3-bit `sel`; all other outputs are 0.
- Built as a tree of 1-to-2 demux stages feeding an 8-bit output register bank, so the result appears one clock edge later.

Parameters:
- None. Widths are fixed: `in` is 1 bit, `sel` is 3 bits, eight 1-bit outputs.

Ports:
- clk  input  1  system clock; rising-edge active
- rst  input  1  asynchronous, active-high reset
- a  output  1  registered; equals `in` when `sel`=0, else 0
- b  output  1  registered; equals `in` when `sel`=1, else 0
- c  output  1  registered; equals `in` when `sel`=2, else 0
- d  output  1  registered; equals `in` when `sel`=3, else 0
- e  output  1  registered; equals `in` when `sel`=4, else 0
- f  output  1  registered; equals `in` when `sel`=5, else 0
- g  output  1  registered; equals `in` when `sel`=6, else 0
- h  output  1  registered; equals `in` when `sel`=7, else 0
- in  input  1  data bit to route
- sel  input  3  output select; `sel`[2] is the MSB

Interface:
- One clock (`clk`); reset `rst` is asynchronous and active-high.
- Positional port order after `clk`, `rst`: `a`, `b`, `c`, `d`, `e`, `f`, `g`, `h`, `in`, `sel`.

Behaviour:
- Combinational decode: out[k] = `in` AND (`sel` == k), for k = 0..7, mapping a..h to k = 0..7.
- Tree structure:
  - Stage 1 splits on `sel`[2] into a low group (a–d) and a high group (e–h).
  - Stage 2 splits on `sel`[1].
  - Stage 3 splits on `sel`[0].
- Registering: the decoded 8-bit vector is captured on each rising `clk`.
- Latency: exactly 1 cycle from a change of `in`/`sel` to the outputs.
- No enable input; the register loads every cycle.
- One-hot property: at most one output is 1 in any cycle.
  - `in`=0 gives all outputs 0 regardless of `sel`.
- Reset:
  - `rst`=1 forces a..h to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while `rst` is held.
  - After `rst` is released, the first rising edge loads the decode of the current `in`/`sel`.
- Reset asserted mid-operation: outputs clear at once; the pending decode is discarded.
- `sel` values are all legal (0..7); there is no invalid or out-of-range case.
- `in` or `sel` containing X/Z: outputs are don't-care in simulation only; no special handling is required.
- No internal state beyond the 8 output flops.

Decomposition:
- Shared package: the constant SEL_W = 3 and the select encodings (SEL_A = 0 … SEL_H = 7), used by this block and by the bench.
- One natural sub-module, `dmux_2way` (`in`, `sel` → `a`, `b`):
  - Instantiated 7 times to form the tree: 1 at stage 1, 2 at stage 2, 4 at stage 3.
  - The top level adds only the 8-bit output register with asynchronous reset.

Test Plan:
- Reset: assert `rst` with `in`=1, `sel`=3 → all outputs read 0 immediately and remain 0 across clock edges while `rst`=1.
- Exhaustive sweep: drive {`in`,`sel`} = 0..15, one value per cycle →
  - values 0..7 (`in`=0): all outputs 0 one cycle later;
  - value 8+k (`in`=1, `sel`=k): only output k is 1 one cycle later (e.g. 13 → f=1, all others 0).
- Latency check: change `sel` from 0 to 7 with `in`=1 → a stays 1 and h stays 0 until the next rising edge, then a=0 and h=1.
- Mid-operation reset: with `in`=1, `sel`=5 and f=1, pulse `rst` between clock edges → f drops to 0 asynchronously; after release, the next edge restores f=1.
- One-hot invariant: random `in`/`sel` for 1000 cycles → the number of 1 outputs is ≤ 1 and equals `in` from the previous cycle; the asserted output index equals the previous cycle's `sel`.
